cnt_seq_checker: RTL

- Receive-side monitor for the team's 3-bit D-flip-flop sequence counter.
- Samples the counter's code {da,db,dc} as a 3-bit bus and locks onto the counter's fixed sequence.
- Reports loop position and flags out-of-sequence and illegal codes.
- Used in benches and as an on-chip sanity monitor downstream of the counter.

---
 rtl/cnt_seq_checker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cnt_seq_checker.sv
// Receive-side monitor that locks onto the 3-bit DFF counter sequence and flags breaks.
// Optional coasting over a single bad sample while locked: define CNT_CHK_FLYWHEEL_EN.
module cnt_seq_checker #(
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       code,
  output logic             locked,
  output logic [1:0]       pos,
  output logic             err,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_dbg
);

  // Handshake: a code is consumed on every posedge where valid=1; there is no backpressure.
  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic             locked_q, locked_d;
  logic [1:0]       pos_q, pos_d;
  logic             err_q, err_d;
  logic             illegal_q, illegal_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
`ifdef CNT_CHK_FLYWHEEL_EN
  logic             miss_q, miss_d;
`endif

  function automatic logic is_illegal(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b100);
  endfunction

  // Illegal codes have no successor; callers gate on is_illegal(prev).
  function automatic logic [2:0] exp_next(input logic [2:0] p);
    case (p)
      3'b000:  exp_next = 3'b011;
      3'b011:  exp_next = 3'b110;
      3'b110:  exp_next = 3'b101;
      3'b101:  exp_next = 3'b010;
      3'b010:  exp_next = 3'b111;
      3'b111:  exp_next = 3'b110;
      default: exp_next = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] loop_idx(input logic [2:0] c);
    case (c)
      3'b101:  loop_idx = 2'd1;
      3'b010:  loop_idx = 2'd2;
      3'b111:  loop_idx = 2'd3;
      default: loop_idx = 2'd0;
    endcase
  endfunction

  logic c_ill, c_match;
  assign c_ill   = is_illegal(code);
  assign c_match = !is_illegal(prev_q) && (code == exp_next(prev_q));

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    match_d   = match_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    illegal_d = 1'b0;
    locked_d  = locked_q;
    pos_d     = pos_q;
`ifdef CNT_CHK_FLYWHEEL_EN
    miss_d    = miss_q;
`endif
    if (valid) begin
      prev_d    = code;
      illegal_d = c_ill;
      case (state_q)
        S_IDLE: begin
          if (!c_ill) begin
            state_d = S_HUNT;
            match_d = '0;
          end
        end
        S_HUNT: begin
          if (c_match) begin
            if (int'(match_q) + 1 == LOCK_CNT) begin
              state_d = S_LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else if (c_ill) begin
            state_d = S_IDLE;
            match_d = '0;
          end else begin
            match_d = '0;
          end
        end
        S_LOCKED: begin
          if (c_match) begin
`ifdef CNT_CHK_FLYWHEEL_EN
            miss_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
            if (cnt_q != {ERR_W{1'b1}}) cnt_d = cnt_q + ERR_W'(1);
            match_d = '0;
            if (c_ill) begin
              state_d = S_IDLE;
`ifdef CNT_CHK_FLYWHEEL_EN
              miss_d  = 1'b0;
`endif
            end else begin
`ifdef CNT_CHK_FLYWHEEL_EN
              if (!miss_q) begin
                // Coast: pretend the expected code arrived.
                miss_d = 1'b1;
                prev_d = exp_next(prev_q);
              end else begin
                miss_d  = 1'b0;
                state_d = S_HUNT;
              end
`else
              state_d = S_HUNT;
`endif
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          match_d = '0;
        end
      endcase
      locked_d = (state_d == S_LOCKED);
      pos_d    = locked_d ? loop_idx(prev_d) : 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      prev_q    <= 3'b000;
      match_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      locked_q  <= 1'b0;
      pos_q     <= 2'd0;
`ifdef CNT_CHK_FLYWHEEL_EN
      miss_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
      locked_q  <= locked_d;
      pos_q     <= pos_d;
`ifdef CNT_CHK_FLYWHEEL_EN
      miss_q    <= miss_d;
`endif
    end
  end

  assign locked    = locked_q;
  assign pos       = pos_q;
  assign err       = err_q;
  assign illegal   = illegal_q;
  assign err_count = cnt_q;
  assign state_dbg = state_q;

endmodule
